pipeline_ctrl: RTL

- Central stall/flush sequencer for the five-stage pipeline. It drives the stall and synchronous-clear (flush) inputs of fetch_decode, decode_execute, execute_memory and memory_writeback.
- It resolves load-use hazards, multi-cycle execute operations, instruction/data memory wait states and branch redirects.
- It tracks a wrong-path fetch kill and keeps a stall performance counter.
- It sits beside the datapath in the core top; the datapath registers stay passive.

---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 34 +++
 rtl/pipeline_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the pipeline stall/flush sequencer.
//
//   common : short scalar/vector aliases used across the core
//            (u1 single bit, u5 register index).
//   pipes  : pipeline-control specific types.
//            ctrl_state_t  - sequencer state (RUN / EX_WAIT)
//            stage_ctrl_t  - stall/flush pair for one pipeline register
//            REG_ZERO      - architectural zero register index
// -----------------------------------------------------------------------------
package common;
    typedef logic       u1;
    typedef logic [4:0] u5;
endpackage : common

package pipes;
    import common::*;

    typedef enum logic {
        RUN     = 1'b0,
        EX_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

    localparam u5 REG_ZERO = 5'd0;
endpackage : pipes

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
//   Purely combinational load-use compare between the instruction in decode
//   and a load sitting in execute. A load targeting x0 never creates a hazard
//   because x0 is never written.
//
// Ports:
//   d_rs1, d_rs2         in  decode source register indices
//   d_use_rs1, d_use_rs2 in  decode instruction actually reads rs1 / rs2
//   e_is_load            in  execute instruction is a load
//   e_rd                 in  execute destination register
//   load_use             out decode must wait one cycle for the load data
// -----------------------------------------------------------------------------
module hazard_detect
    import common::*;
    import pipes::*;
(
    input  u5 d_rs1,
    input  u5 d_rs2,
    input  u1 d_use_rs1,
    input  u1 d_use_rs2,
    input  u1 e_is_load,
    input  u5 e_rd,
    output u1 load_use
);

    u1 rs1_hit;
    u1 rs2_hit;

    assign rs1_hit  = d_use_rs1 && (d_rs1 == e_rd);
    assign rs2_hit  = d_use_rs2 && (d_rs2 == e_rd);
    assign load_use = e_is_load && (e_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the five-stage pipeline. Drives the
//   stall and synchronous-clear inputs of the fetch_decode, decode_execute,
//   execute_memory and memory_writeback registers, which stay passive.
//
//   Each cycle exactly one condition wins, in this order:
//     1. data memory wait     : freeze everything, bubble into writeback
//     2. multi-cycle execute  : freeze F/D/E, bubble into memory
//     3. branch redirect      : squash decode and execute, no stalls
//     4. load-use hazard      : freeze F/D, bubble into execute
//     5. instruction mem wait : freeze PC, bubble into decode
//   stall_* and flush_* are combinational, valid in the cycle the hazard is
//   visible. A register is never stalled and flushed in the same cycle.
//
// Ports:
//   clk               in  core clock, rising edge
//   reset             in  asynchronous active-low reset
//   imem_busy         in  fetch waiting on instruction memory
//   dmem_busy         in  memory stage waiting on data memory
//   d_rs1, d_rs2      in  decode source register indices
//   d_use_rs1/2       in  decode reads rs1 / rs2
//   e_is_load         in  execute instruction is a load
//   e_rd              in  execute destination register
//   ex_multi_start    in  execute holds a multi-cycle mul/div
//   ex_multi_done     in  one-cycle pulse, multi-cycle result ready
//   branch_redirect   in  execute resolved a taken branch/jump
//   stall_f/d/e/m     out hold PC / fetch_decode / decode_execute / execute_memory
//   flush_d/e/m/w     out clear fetch_decode / decode_execute / execute_memory /
//                         memory_writeback to a bubble
//   fetch_kill        out discard the next instruction returned by imem
//   ex_timeout        out sticky, multi-cycle watchdog fired
//   perf_stall_cnt    out cycles with stall_f asserted (wraps)
//   dbg_state         out current sequencer state
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import common::*;
    import pipes::*;
#(
    parameter int MAX_EX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic             e_is_load,
    input  logic [4:0]       e_rd,
    input  logic             ex_multi_start,
    input  logic             ex_multi_done,
    input  logic             branch_redirect,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             fetch_kill,
    output logic             ex_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output ctrl_state_t      dbg_state
);

    localparam int EX_CNT_W = (MAX_EX_CYCLES > 2) ? $clog2(MAX_EX_CYCLES) : 1;
    localparam logic [EX_CNT_W-1:0] EX_CNT_LAST = EX_CNT_W'(MAX_EX_CYCLES - 1);

    ctrl_state_t         state;
    ctrl_state_t         state_next;
    logic [EX_CNT_W-1:0] ex_cnt;
    logic [EX_CNT_W-1:0] ex_cnt_next;
    logic                timeout_fire;
    logic                kill_set;
    logic                multi_wait;
    u1                   load_use;

    logic                pc_stall;
    stage_ctrl_t         ctl_d;
    stage_ctrl_t         ctl_e;
    stage_ctrl_t         ctl_m;
    stage_ctrl_t         ctl_w;

    hazard_detect u_hazard_detect (
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_use_rs1 (d_use_rs1),
        .d_use_rs2 (d_use_rs2),
        .e_is_load (e_is_load),
        .e_rd      (e_rd),
        .load_use  (load_use)
    );

    // The done cycle of a multi-cycle op is not stalled: the result leaves
    // execute that cycle, so lower-priority conditions get to act on it.
    assign multi_wait = !ex_multi_done &&
                        ((state == EX_WAIT) || ((state == RUN) && ex_multi_start));

    // -------------------------------------------------------------------------
    // Stall / flush selection
    // -------------------------------------------------------------------------
    always_comb begin
        pc_stall = 1'b0;
        ctl_d    = '0;
        ctl_e    = '0;
        ctl_m    = '0;
        ctl_w    = '0;
        kill_set = 1'b0;

        if (!reset) begin
            // Clear every pipeline register while the core is held in reset.
            ctl_d.flush = 1'b1;
            ctl_e.flush = 1'b1;
            ctl_m.flush = 1'b1;
            ctl_w.flush = 1'b1;
        end else if (dmem_busy) begin
            pc_stall    = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.stall = 1'b1;
            ctl_m.stall = 1'b1;
            ctl_w.flush = 1'b1;
        end else if (multi_wait) begin
            pc_stall    = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.stall = 1'b1;
            ctl_m.flush = 1'b1;
        end else if (branch_redirect) begin
            ctl_d.flush = 1'b1;
            ctl_e.flush = 1'b1;
            // The fetch still in flight belongs to the wrong path.
            kill_set    = imem_busy;
        end else if (load_use) begin
            // One cycle suffices: the flushed bubble replaces the load in
            // execute, so the compare clears on its own next cycle.
            pc_stall    = 1'b1;
            ctl_d.stall = 1'b1;
            ctl_e.flush = 1'b1;
        end else if (imem_busy) begin
            pc_stall    = 1'b1;
            ctl_d.flush = 1'b1;
        end
    end

    assign stall_f = pc_stall;
    assign stall_d = ctl_d.stall;
    assign stall_e = ctl_e.stall;
    assign stall_m = ctl_m.stall;
    assign flush_d = ctl_d.flush;
    assign flush_e = ctl_e.flush;
    assign flush_m = ctl_m.flush;
    assign flush_w = ctl_w.flush;

    // -------------------------------------------------------------------------
    // Sequencer next state and watchdog counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        ex_cnt_next  = ex_cnt;
        timeout_fire = 1'b0;

        unique case (state)
            RUN: begin
                if (ex_multi_start && !ex_multi_done && !dmem_busy) begin
                    state_next = EX_WAIT;
                end
            end
            EX_WAIT: begin
                // A data-memory wait freezes the whole pipeline, including
                // the watchdog, so memory latency never counts against it.
                if (!dmem_busy) begin
                    if (ex_multi_done) begin
                        state_next  = RUN;
                        ex_cnt_next = '0;
                    end else if (ex_cnt == EX_CNT_LAST) begin
                        state_next   = RUN;
                        ex_cnt_next  = '0;
                        timeout_fire = 1'b1;
                    end else begin
                        ex_cnt_next = ex_cnt + EX_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next  = RUN;
                ex_cnt_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= RUN;
            ex_cnt         <= '0;
            ex_timeout     <= 1'b0;
            fetch_kill     <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state  <= state_next;
            ex_cnt <= ex_cnt_next;

            if (timeout_fire) begin
                ex_timeout <= 1'b1;
            end

            // The first cycle imem is no longer busy returns the wrong-path
            // instruction; the kill covers exactly that one.
            if (kill_set) begin
                fetch_kill <= 1'b1;
            end else if (!imem_busy) begin
                fetch_kill <= 1'b0;
            end

            if (pc_stall) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign dbg_state = state;

endmodule : pipeline_ctrl
